d_grf: RTL and testbench

//   General register file for the D stage of the 5-stage MIPS pipeline. It sits

---
 rtl/d_grf.sv | 80 ++++++++
 tb/tb_d_grf.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/d_grf.sv
`default_nettype none
// ============================================================================
//  Module   : d_grf
//  Purpose  : D-stage general register file, two combinational read ports and
//             one W-stage write port with write-first bypass into same-cycle reads.
//  Revision : 1.0 - initial release
// ============================================================================
module d_grf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] D_A1,
    input  logic [ADDR_W-1:0] D_A2,
    input  logic              W_WE,
    input  logic [ADDR_W-1:0] W_A3,
    input  logic [DATA_W-1:0] W_WD,
    output logic [DATA_W-1:0] D_RD1,
    output logic [DATA_W-1:0] D_RD2
);

    localparam int c_NREGS = 2 ** ADDR_W;

    // Entry 0 is a constant zero, so every index lands on a defined value.
    logic [DATA_W-1:0] w_file [0:c_NREGS-1];
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_byp1;
    logic              w_byp2;

    assign w_file[0] = '0;

    generate
        for (genvar gi = 1; gi < c_NREGS; gi++) begin : g_entry
            logic [DATA_W-1:0] r_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_q <= '0;
                end else if (W_WE && (W_A3 == ADDR_W'(gi))) begin
                    r_q <= W_WD;
                end
            end

            assign w_file[gi] = r_q;
        end
    endgenerate

    assign w_byp1 = W_WE && (W_A3 == D_A1);
    assign w_byp2 = W_WE && (W_A3 == D_A2);

    // Reads are held at zero while reset is low, which also masks the bypass.
    always_comb begin
        w_rd1 = '0;
        if (reset && (D_A1 != '0)) begin
            if (w_byp1) begin
                w_rd1 = W_WD;
            end else begin
                w_rd1 = w_file[D_A1];
            end
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (reset && (D_A2 != '0)) begin
            if (w_byp2) begin
                w_rd2 = W_WD;
            end else begin
                w_rd2 = w_file[D_A2];
            end
        end
    end

    assign D_RD1 = w_rd1;
    assign D_RD2 = w_rd2;

endmodule
`default_nettype wire

// File: tb/tb_d_grf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_d_grf
//  Purpose  : Self-checking bench for d_grf (vector table plus random traffic
//             against a behavioural register-file model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_d_grf;

    localparam int c_DW = 32;
    localparam int c_AW = 5;
    localparam int c_N  = 32;

    logic            clk;
    logic            reset;
    logic [c_AW-1:0] D_A1;
    logic [c_AW-1:0] D_A2;
    logic            W_WE;
    logic [c_AW-1:0] W_A3;
    logic [c_DW-1:0] W_WD;
    logic [c_DW-1:0] D_RD1;
    logic [c_DW-1:0] D_RD2;

    int checks   = 0;
    int failures = 0;

    logic [c_DW-1:0] mdl [0:c_N-1];

    typedef struct {
        logic [c_AW-1:0] a1;
        logic [c_AW-1:0] a2;
        logic            we;
        logic [c_AW-1:0] a3;
        logic [c_DW-1:0] wd;
        logic [c_DW-1:0] e1;
        logic [c_DW-1:0] e2;
    } vec_t;

    vec_t vecs [0:12];

    d_grf #(.DATA_W(c_DW), .ADDR_W(c_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .D_A1  (D_A1),
        .D_A2  (D_A2),
        .W_WE  (W_WE),
        .W_A3  (W_A3),
        .W_WD  (W_WD),
        .D_RD1 (D_RD1),
        .D_RD2 (D_RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [c_DW-1:0] model_read(input logic [c_AW-1:0] a, input logic we,
                                                   input logic [c_AW-1:0] a3, input logic [c_DW-1:0] wd);
        if (a == 0) return '0;
        if (we && a3 == a) return wd;
        return mdl[a];
    endfunction

    // One pipeline cycle: drive at the falling edge, compare before the rising edge.
    task automatic cycle(input logic [c_AW-1:0] a1, input logic [c_AW-1:0] a2, input logic we,
                         input logic [c_AW-1:0] a3, input logic [c_DW-1:0] wd,
                         input logic [c_DW-1:0] e1, input logic [c_DW-1:0] e2, input string nm);
        @(negedge clk);
        D_A1 = a1; D_A2 = a2; W_WE = we; W_A3 = a3; W_WD = wd;
        #2;
        check({nm, "_rd1"}, D_RD1, e1);
        check({nm, "_rd2"}, D_RD2, e2);
        @(posedge clk);
        #1;
        if (reset && we && a3 != 0) mdl[a3] = wd;
    endtask

    task automatic sweep_zero(input string nm);
        W_WE = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            D_A1 = c_AW'(i);
            D_A2 = c_AW'(c_N - 1 - i);
            #1;
            check($sformatf("%s_rd1_%0d", nm, i), D_RD1, '0);
            check($sformatf("%s_rd2_%0d", nm, c_N - 1 - i), D_RD2, '0);
        end
    endtask

    initial begin
        logic [c_AW-1:0] a1, a2, a3;
        logic            we;
        logic [c_DW-1:0] wd;

        vecs[0]  = '{5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{5'd5, 5'd5, 1'b0, 5'd5, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h0,        32'h0};
        vecs[3]  = '{5'd0, 5'd0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0,        32'h0};
        vecs[4]  = '{5'd7, 5'd7, 1'b1, 5'd7, 32'h1,        32'h1,        32'h1};
        vecs[5]  = '{5'd5, 5'd7, 1'b0, 5'd7, 32'h12345678, 32'hDEADBEEF, 32'h1};
        vecs[6]  = '{5'd7, 5'd7, 1'b0, 5'd7, 32'h12345678, 32'h1,        32'h1};
        vecs[7]  = '{5'd3, 5'd4, 1'b1, 5'd3, 32'hA,        32'hA,        32'h0};
        vecs[8]  = '{5'd3, 5'd4, 1'b1, 5'd4, 32'hA,        32'hA,        32'hA};
        vecs[9]  = '{5'd3, 5'd4, 1'b1, 5'd4, 32'hB,        32'hA,        32'hB};
        vecs[10] = '{5'd4, 5'd4, 1'b0, 5'd4, 32'h0,        32'hB,        32'hB};
        vecs[11] = '{5'd4, 5'd4, 1'b1, 5'd4, 32'hC,        32'hC,        32'hC};
        vecs[12] = '{5'd4, 5'd3, 1'b0, 5'd0, 32'h0,        32'hC,        32'hA};

        for (int i = 0; i < c_N; i++) mdl[i] = '0;

        // Reset held low with a write and a would-be bypass presented.
        reset = 1'b0;
        D_A1 = 5'd5; D_A2 = 5'd6; W_WE = 1'b1; W_A3 = 5'd5; W_WD = 32'h55AA55AA;
        #2;
        check("rst_bypass_rd1", D_RD1, '0);
        check("rst_rd2", D_RD2, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        W_WE = 1'b0;
        reset = 1'b1;
        #1;
        sweep_zero("post_reset");

        for (int i = 0; i < 13; i++)
            cycle(vecs[i].a1, vecs[i].a2, vecs[i].we, vecs[i].a3, vecs[i].wd,
                  vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));

        for (int n = 0; n < 400; n++) begin
            a1 = c_AW'($urandom);
            a2 = c_AW'($urandom);
            we = 1'($urandom_range(0, 1));
            a3 = ($urandom_range(0, 3) == 0) ? a1 : c_AW'($urandom);
            wd = $urandom;
            cycle(a1, a2, we, a3, wd, model_read(a1, we, a3, wd), model_read(a2, we, a3, wd),
                  $sformatf("rnd%0d", n));
        end

        // Fill every entry with its index, then confirm storage without bypass.
        for (int i = 1; i < c_N; i++)
            cycle(c_AW'(i), 5'd0, 1'b1, c_AW'(i), c_DW'(i), c_DW'(i), '0, $sformatf("fill%0d", i));
        cycle(5'd9, 5'd31, 1'b0, 5'd0, '0, 32'd9, 32'd31, "filled");

        // Asynchronous reset mid-cycle with a write to entry 9 pending.
        @(negedge clk);
        D_A1 = 5'd9; D_A2 = 5'd31; W_WE = 1'b1; W_A3 = 5'd9; W_WD = 32'hCAFEF00D;
        #1;
        check("pre_async_byp", D_RD1, 32'hCAFEF00D);
        #1;
        reset = 1'b0;
        #1;
        check("async_rd1", D_RD1, '0);
        check("async_rd2", D_RD2, '0);
        @(posedge clk);
        #1;
        check("async_hold_rd1", D_RD1, '0);
        @(negedge clk);
        W_WE = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < c_N; i++) mdl[i] = '0;
        #1;
        sweep_zero("after_async");
        cycle(5'd9, 5'd1, 1'b0, 5'd9, 32'hCAFEF00D, 32'h0, 32'h0, "reg9_cleared");
        cycle(5'd9, 5'd2, 1'b1, 5'd2, 32'h600D, 32'h0, 32'h600D, "first_write");
        cycle(5'd2, 5'd9, 1'b0, 5'd0, 32'h0, 32'h600D, 32'h0, "first_write_stored");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
